// File: rtl/microtile_arb_pkg.sv
// Shared types and limits for the microtile request arbiter.
package microtile_arb_pkg;
  localparam int ARB_MAX_N = 8;

  typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_e;
  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} arb_state_e;
endpackage

// File: rtl/arb_rotate_pick.sv
// Circular first-set search over req & mask, starting at 'start' and wrapping N_REQ-1 -> 0.
module arb_rotate_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  winner
);
  logic [N_REQ-1:0] cand;
  assign cand = req & mask;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (cand[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/microtile_arbiter.sv
// Registered N-channel arbiter: fixed-priority or round-robin, grant locking, optional hold limit.
module microtile_arbiter
  import microtile_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 0,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  input  logic [ID_W-1:0]  prio_sel,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id
);
  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  id_d, rr_q, rr_d, start, winner;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [N_REQ-1:0] mask, gnt_d;
  logic             found, own_req, at_limit, forced;

  assign start    = (arb_mode_e'(mode) == RR) ? rr_q
                  : ((int'(prio_sel) < N_REQ) ? prio_sel : '0);
  assign own_req  = (state_q == OWNED) && req[gnt_id];
  assign at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign forced   = own_req && at_limit;
  // On a forced release the owner is excluded so any other requester wins first.
  assign mask     = forced ? ~(N_REQ'(1) << gnt_id) : '1;

  arb_rotate_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (req),
    .mask   (mask),
    .start  (start),
    .found  (found),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      hold_q    <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_valid <= (state_d == OWNED);
      gnt_id    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = gnt_id;
    rr_d    = rr_q;
    hold_d  = hold_q;
    if (own_req && !at_limit) begin
      if (hold_q != '1) hold_d = hold_q + 1'b1;
    end else if (found) begin
      state_d = OWNED;
      id_d    = winner;
      hold_d  = '0;
      rr_d    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end else if (!own_req) begin
      // Owner gone and nobody else asking; a saturated forced hold falls through unchanged.
      state_d = IDLE;
    end
  end

  always_comb begin
    gnt_d = '0;
    if (state_d == OWNED) gnt_d[id_d] = 1'b1;
  end
endmodule

// File: tb/tb_microtile_arbiter.sv
// Scoreboarded bench: four arbiter configurations against a behavioural model plus directed checks.
module tb_microtile_arbiter;
  typedef struct packed { bit own; int id; int hold; int rr; } mst_t;
  typedef struct packed {
    logic [3:0][7:0] g;
    logic [3:0]      v;
    logic [3:0][7:0] id;
  } exp_t;

  localparam int NN [4] = '{2, 4, 4, 3};
  localparam int MH [4] = '{0, 0, 3, 0};

  logic clk = 1'b0;
  logic rst;
  logic [3:0][7:0] rq, ps;
  logic [3:0]      md;

  logic [1:0] g2; logic [3:0] g4, gh; logic [2:0] g3;
  logic v2, v4, vh, v3;
  logic [0:0] i2; logic [1:0] i4, ih, i3;
  logic [3:0][7:0] ag, ai;
  logic [3:0]      av;

  mst_t ms [4];
  exp_t sbq [$];
  int   n_cmp, n_err;

  always #5 clk = ~clk;

  assign ag = {5'b0, g3, 4'b0, gh, 4'b0, g4, 6'b0, g2};
  assign ai = {6'b0, i3, 6'b0, ih, 6'b0, i4, 7'b0, i2};
  assign av = {v3, vh, v4, v2};

  microtile_arbiter #(.N_REQ(2), .MAX_HOLD(0)) u2 (.clk(clk), .rst(rst), .req(rq[0][1:0]),
    .mode(md[0]), .prio_sel(ps[0][0:0]), .gnt(g2), .gnt_valid(v2), .gnt_id(i2));
  microtile_arbiter #(.N_REQ(4), .MAX_HOLD(0)) u4 (.clk(clk), .rst(rst), .req(rq[1][3:0]),
    .mode(md[1]), .prio_sel(ps[1][1:0]), .gnt(g4), .gnt_valid(v4), .gnt_id(i4));
  microtile_arbiter #(.N_REQ(4), .MAX_HOLD(3)) uh (.clk(clk), .rst(rst), .req(rq[2][3:0]),
    .mode(md[2]), .prio_sel(ps[2][1:0]), .gnt(gh), .gnt_valid(vh), .gnt_id(ih));
  microtile_arbiter #(.N_REQ(3), .MAX_HOLD(0)) u3 (.clk(clk), .rst(rst), .req(rq[3][2:0]),
    .mode(md[3]), .prio_sel(ps[3][1:0]), .gnt(g3), .gnt_valid(v3), .gnt_id(i3));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [7:0] r, int n, int st, int excl);
    for (int k = 0; k < n; k++) begin
      int j;
      j = (st + k) % n;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic mst_t nxt(mst_t s, int i);
    int n, mh, st, w;
    n  = NN[i];
    mh = MH[i];
    if (rst) return '{own: 1'b0, id: 0, hold: 0, rr: 0};
    st = md[i] ? s.rr : ((int'(ps[i]) < n) ? int'(ps[i]) : 0);
    if (!s.own || !rq[i][s.id]) begin
      w = pick(rq[i], n, st, -1);
    end else if (mh == 0 || s.hold < mh - 1) begin
      s.hold++;
      return s;
    end else begin
      w = pick(rq[i], n, st, s.id);
      if (w < 0) return s;
    end
    if (w < 0) begin
      s.own = 1'b0;
      return s;
    end
    s.own = 1'b1; s.id = w; s.hold = 0; s.rr = (w + 1) % n;
    return s;
  endfunction

  // Predict the post-edge outputs, push them, clock once, then pop and compare.
  task automatic step();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      ms[i]   = nxt(ms[i], i);
      e.g[i]  = ms[i].own ? 8'(1 << ms[i].id) : 8'h00;
      e.v[i]  = ms[i].own;
      e.id[i] = 8'(ms[i].id);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("sb_gnt%0d", i), 32'(ag[i]), 32'(e.g[i]));
        chk($sformatf("sb_vld%0d", i), 32'(av[i]), 32'(e.v[i]));
        chk($sformatf("sb_id%0d", i), 32'(ai[i]), 32'(e.id[i]));
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int rrseq [5];
    int hseq  [9];
    rrseq = '{0, 1, 2, 3, 0};
    hseq  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    n_cmp = 0; n_err = 0;
    for (int i = 0; i < 4; i++) ms[i] = '{own: 1'b0, id: 0, hold: 0, rr: 0};
    rq = '0; ps = '0; md = '0;
    rst = 1'b1;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_gnt%0d", i), 32'(ag[i]), 32'd0);
      chk($sformatf("rst_vld%0d", i), 32'(av[i]), 32'd0);
      chk($sformatf("rst_id%0d", i), 32'(ai[i]), 32'd0);
    end
    rst = 1'b0;

    // Two-input legacy behaviour
    rq[0] = 8'b11; ps[0] = 8'd0; step();
    chk("leg_p0", 32'(ag[0]), 32'h1);
    do_reset(); ps[0] = 8'd1; step();
    chk("leg_p1", 32'(ag[0]), 32'h2);
    do_reset(); rq[0] = 8'b10; ps[0] = 8'd0; step();
    chk("leg_solo", 32'(ag[0]), 32'h2);

    // Round-robin fairness on u4, hold limit with contention on uh
    do_reset();
    md[1] = 1'b1; rq[1] = 8'hF;
    md[2] = 1'b1; rq[2] = 8'h3;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("hold_id%0d", k), 32'(ai[2]), hseq[k]);
      if (k < 5) begin
        chk($sformatf("rr_id%0d", k), 32'(ai[1]), rrseq[k]);
        rq[1] = 8'hF & ~(8'h1 << rrseq[k]);
      end
    end
    rq[2] = 8'h1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("hold_solo%0d", k), 32'(ag[2]), 32'h1);
    end

    // Non-power-of-two: RR alternation, out-of-range prio_sel
    do_reset();
    md[3] = 1'b1; rq[3] = 8'b101; step();
    chk("np2_a", 32'(ai[3]), 32'd0);
    rq[3] = 8'b100; step();
    chk("np2_b", 32'(ai[3]), 32'd2);
    rq[3] = 8'b001; step();
    chk("np2_c", 32'(ai[3]), 32'd0);
    do_reset();
    md[3] = 1'b0; ps[3] = 8'd3; rq[3] = 8'b110; step();
    chk("np2_prio3a", 32'(ai[3]), 32'd1);
    rq[3] = 8'b101; step();
    chk("np2_prio3b", 32'(ai[3]), 32'd0);

    // Owner 2 survives a mode switch; reset mid-grant clears it
    do_reset();
    md[1] = 1'b0; ps[1] = 8'd0; rq[1] = 8'h4; step();
    chk("ms_own", 32'(ag[1]), 32'h4);
    md[1] = 1'b1; rq[1] = 8'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("ms_keep%0d", k), 32'(ag[1]), 32'h4);
    end
    rst = 1'b1; step();
    chk("mr_gnt", 32'(ag[1]), 32'h0);
    chk("mr_vld", 32'(av[1]), 32'h0);
    chk("mr_id", 32'(ai[1]), 32'h0);
    rst = 1'b0; step();
    chk("mr_first", 32'(ai[1]), 32'd0);

    // After the switch, the next winner follows round-robin from rr_ptr=3
    do_reset();
    md[1] = 1'b0; ps[1] = 8'd0; rq[1] = 8'h4; step();
    md[1] = 1'b1; rq[1] = 8'hF; step();
    chk("ms_hold", 32'(ai[1]), 32'd2);
    rq[1] = 8'hB; step();
    chk("ms_next", 32'(ai[1]), 32'd3);

    // Random traffic on every configuration
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        rq[i] = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
        md[i] = 1'($urandom_range(0, 1));
        ps[i] = 8'($urandom_range(0, (i == 0) ? 1 : 3));
      end
      if (k % 97 == 50) rst = 1'b1;
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/microtile_arbiter.md
# microtile_arbiter

Parametrised N-channel request arbiter for the microtile collection. It generalises the two-input mutual-exclusion grant tile, where a select pin decides the winner on a conflict, into a registered arbiter. Features: N requesters, selectable fixed-priority or round-robin policy, grant locking while the owner holds its request, and an optional hold limit that forces rotation. It sits between `ui_in` request pins and `uo_out` grant pins of a tile wrapper. The wrapper inverts `rst_n` into `rst`.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `MAX_HOLD`, default 0: maximum consecutive grant cycles per owner before a forced release; 0 means unlimited.
- `ID_W`, default `$clog2(N_REQ)`: width of channel index; derived, not overridden.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: request per channel, level-sensitive.
- `mode`  in  1: 0 = fixed priority, 1 = round-robin.
- `prio_sel`  in  ID_W: highest-priority channel in fixed mode; values ≥ N_REQ are treated as 0.
- `gnt`  out  N_REQ: registered one-hot grant; all-zero when idle.
- `gnt_valid`  out  1: OR of `gnt`, registered.
- `gnt_id`  out  ID_W: index of the granted channel; holds its last value when idle.

## Operation
- States: IDLE (no owner) and OWNED (owner = `gnt_id`, hold counter `hold_cnt` running).
- IDLE:
  - If any `req` is set, arbitrate and go to OWNED with the winner, `hold_cnt` = 0.
  - Otherwise stay in IDLE.
- OWNED, with owner o:
  - `req[o]`=0: re-arbitrate among the current `req`. Go to OWNED with the new winner, or to IDLE if `req` is all-zero.
  - `req[o]`=1 and (`MAX_HOLD`=0 or `hold_cnt` < `MAX_HOLD`-1): keep o and increment `hold_cnt`. `hold_cnt` saturates, no wrap.
  - `req[o]`=1 and `hold_cnt` = `MAX_HOLD`-1: arbitrate with o masked out.
    - If another channel wins, grant it with `hold_cnt` = 0.
    - If no other request exists, keep o with `hold_cnt` saturated; the forced release re-evaluates every cycle.
- Arbitration is a circular search for the first set, unmasked `req` bit from a start index, wrapping N_REQ-1 → 0 (also for non-power-of-two N_REQ).
  - Fixed mode: start = `prio_sel`.
  - Round-robin mode: start = `rr_ptr`.
- `rr_ptr` (ID_W bits, reset 0) updates to (winner+1) mod N_REQ on every new grant. This happens in both modes, so switching to round-robin continues fairly.
- `mode` and `prio_sel` affect only new arbitration decisions. They never preempt a current owner.
- Grant is never given to a channel whose `req` is 0 in the sampling cycle.

## Timing
- Reset values: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `rr_ptr`=0, `hold_cnt`=0, state IDLE.
- `rst` has priority over all other inputs. Asserting it mid-grant clears the grant at the next edge.
- Request-to-grant latency: `req` sampled at edge t gives `gnt` valid after edge t (1 cycle).
- Release handoff is zero-bubble:
  - Owner drops `req` before edge t.
  - After edge t, the old grant is gone and the new winner is granted in the same update.
  - At most one `gnt` bit is ever high.
- Forced rotation: with `MAX_HOLD`=M and contention, the owner holds exactly M cycles.
- Outputs are direct flop outputs, with no combinational path from inputs.

## Structure
- Package `microtile_arb_pkg`:
  - `arb_mode_e` (FIXED=0, RR=1)
  - `arb_state_e` (IDLE, OWNED)
  - constant `ARB_MAX_N` = 8
- Sub-module `arb_rotate_pick`: purely combinational.
  - Inputs: `req`, `mask`, start index.
  - Outputs: `found` and `winner` index.
  - Instantiated once; the top holds the FSM, `hold_cnt` and `rr_ptr`.

## Test plan
- Legacy equivalence, N_REQ=2, fixed mode, `MAX_HOLD`=0:
  - `req`=11, `prio_sel`=0 → `gnt`=01.
  - `prio_sel`=1 from reset with `req`=11 → `gnt`=10.
  - `req`=10 alone → `gnt`=10 one cycle later.
- Round-robin fairness, N_REQ=4: `req`=1111, each owner drops `req` for one cycle after being granted → `gnt_id` sequence 0,1,2,3,0.
- Hold limit, N_REQ=4, `MAX_HOLD`=3, RR mode:
  - `req`=0011 constantly → channel 0 granted 3 cycles, then channel 1 for 3, then channel 0.
  - `req`=0001 only → channel 0 held indefinitely.
- Non-power-of-two, N_REQ=3, RR, `req`=101 → grants alternate 0,2,0. `prio_sel`=3 in fixed mode behaves as 0.
- Mode switch mid-grant: owner 2 held, `mode` toggled → no change until `req[2]` drops; the next winner follows the new policy.
- Reset mid-operation: assert `rst` for 1 cycle while `gnt`=0100 → next edge all outputs 0, `rr_ptr`=0. First grant after release with `req`=1111 in RR mode → channel 0.
